// File: rtl/keypad_digit_buffer.sv
// rtl/keypad_digit_buffer.sv - debounced keypad digit entry register; ENTRY_TIMEOUT_EN adds idle auto-clear
module keypad_digit_buffer #(
  parameter int DIGITS         = 4,
  parameter int DEBOUNCE       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4:0]                   code_in,
  input  logic                         clear,
  output logic [4*DIGITS-1:0]          digits_out,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         full,
  output logic                         key_strobe,
  output logic                         key_reject,
  output logic                         timeout
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  if (DIGITS < 1 || DEBOUNCE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("keypad_digit_buffer: DIGITS, DEBOUNCE and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  state_t               state;
  logic [DW-1:0]        cnt;
  logic [3:0]           cand;
  logic                 key_valid;
  logic                 match;
  logic                 cnt_last;
  logic                 accept;
  logic                 timeout_hit;
  logic [4*DIGITS-1:0]  shifted;

  // Codes with the present flag but a non-BCD value are treated as no key.
  assign key_valid = code_in[4] && (code_in[3:0] <= 4'd9);
  assign match     = key_valid && (code_in[3:0] == cand);
  assign cnt_last  = (cnt == DW'(DEBOUNCE - 1));
  assign accept    = (state == S_DEBOUNCE) && match && cnt_last;
  assign full      = (digit_count == CW'(DIGITS));

  // New digit enters at the low nibble; the oldest falls off the top.
  always_comb begin
    shifted      = digits_out << 4;
    shifted[3:0] = cand;
  end

  // Press/release debounce FSM; clear deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_valid) begin
            cand  <= code_in[3:0];
            cnt   <= '0;
            state <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (!match) begin
            state <= S_IDLE;
          end else if (cnt_last) begin
            state <= S_HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (!key_valid) begin
            cnt   <= '0;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (key_valid) begin
            state <= S_HELD;
          end else if (cnt_last) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Entry register: clear beats accept, accept beats auto-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_out  <= '0;
      digit_count <= '0;
      key_strobe  <= 1'b0;
      key_reject  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      key_reject <= 1'b0;
      if (clear) begin
        digits_out  <= '0;
        digit_count <= '0;
      end else if (accept) begin
        if (full) begin
          key_reject <= 1'b1;
        end else begin
          digits_out  <= shifted;
          digit_count <= digit_count + 1'b1;
          key_strobe  <= 1'b1;
        end
      end else if (timeout_hit) begin
        digits_out  <= '0;
        digit_count <= '0;
      end
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (state == S_IDLE) && (digit_count != '0) &&
                       (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter only advances while a partial entry sits untouched in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (clear || accept || (state != S_IDLE) || (digit_count == '0) || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Timeout pulse is suppressed when a manual clear lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_hit && !clear;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule
